coin_wallet: RTL and testbench
==============================

# coin_wallet

Balance keeper for the washing-machine controller: holds the customer's 3-digit BCD credit and drives it onto the `bal` input of the billing block. It accepts coin top-ups, freezes the balance while a wash is being billed, and on completion subtracts the fee that billing reports on `income`. It closes the loop opposite the billing block: billing reads `bal` and writes `income`/`next`; this block writes `bal` and reads `income`/`next`.

## Interface
- `TICKS_PER_SEC`, default 100_000_000, clock cycles per second.
- `TIMEOUT_SEC`, default 10, idle seconds before an uncommitted top-up is discarded.
- `clk  in  1  system clock`
- `rst  in  1  reset, asynchronous, active-low`
- `on  in  1  billing active; high = wash in progress, balance locked`
- `add_pos  in  1  one-cycle coin-insert pulse`
- `denom  in  2  coin value for add_pos: 00=1, 01=5, 10=10, 11=50`
- `confirm_pos  in  1  one-cycle pulse; commit pending amount`
- `cancel_pos  in  1  one-cycle pulse; discard pending amount`
- `income  in  12  BCD fee from billing, valid while nonzero during a wash`
- `next  in  1  billing finished; rising edge ends the wash`
- `bal  out  12  committed balance, 3 BCD digits`
- `pend  out  12  pending top-up, 3 BCD digits`
- `busy  out  1  high in BUSY and SETTLE`
- `sat  out  1  one-cycle pulse when a top-up or commit is clipped at 999`
- `short  out  1  one-cycle pulse when a deduction exceeds the balance`

## Operation
- States: IDLE, TOPUP, BUSY, SETTLE.
- IDLE:
  - `add_pos` → pend = coin value, go to TOPUP.
  - `on`=1 → go to BUSY.
- TOPUP:
  - `add_pos` → pend += coin. If bal+pend would exceed 999, clamp pend so bal+pend=999 and pulse `sat`.
  - `confirm_pos` → bal += pend, pend=0, go to IDLE.
  - `cancel_pos` or timeout → pend=0, go to IDLE.
  - Priority: confirm > cancel > add. A simultaneous lower-priority pulse is dropped.
  - `on` rising in TOPUP → pend discarded, go to BUSY. `on` outranks all pulses.
- BUSY:
  - `add_pos`, `confirm_pos` and `cancel_pos` are ignored. bal is held constant.
  - Each cycle `income`≠0, latch it into `hold`.
  - `next` rising edge (next=1, registered next_d=0) → go to SETTLE.
  - `on` falls without a `next` edge → go to IDLE, no deduction, hold cleared.
- SETTLE (exactly one cycle):
  - If hold ≤ bal: bal -= hold. Otherwise bal=0 and pulse `short`.
  - hold=0, go to IDLE. `on` is ignored.
- All arithmetic is digit-wise BCD with carry/borrow. Digits never exceed 9.

## Timing
- Reset values: bal=000, pend=000, busy=0, sat=0, short=0, hold=0, state IDLE, timeout counter 0, next_d=0.
- All outputs are registered. Reset mid-wash clears everything, with no deduction.
- Commit latency: bal updates on the cycle after `confirm_pos` is sampled.
- Deduction latency: `next` edge sampled at cycle N → SETTLE at N+1 → new bal and IDLE at N+2.
- `busy` rises the cycle after `on` is sampled high. It falls at the transition out of SETTLE.
- Timeout: a counter runs in TOPUP and restarts on each accepted `add_pos`. It expires after TIMEOUT_SEC·TICKS_PER_SEC cycles with no pulse. The counter is 31 bits wide.
- `next` held high for many cycles produces one deduction only (edge detect).

## Structure
- Shared package `wallet_pkg`:
  - state enum
  - denomination constants (BCD 001/005/010/050)
  - BCD_MAX = 12'h999
- Sub-module `bcd3_addsub`: combinational 3-digit BCD add/subtract. Outputs are result, carry-out (overflow) and borrow-out (underflow). It is used for top-up, commit and settle.

## Test plan
- Reset, then add 50, 10, 5, 1 and confirm → pend 066 before commit; bal=066, pend=000 after commit.
- bal=990, add 50 → pend=009 and a `sat` pulse; confirm → bal=999.
- bal=120, on=1, income pulses 045 then drops to 000, next rises and stays high 5 cycles → exactly one deduction, bal=075 two cycles after the edge.
- bal=030, held income 045, next edge → bal=000 and one `short` pulse.
- TOPUP with pend=005 and no input for the full timeout (TICKS_PER_SEC=10, TIMEOUT_SEC=2 in the bench) → pend=000 at cycle 20, bal unchanged.
- `on` rises during TOPUP with a simultaneous confirm → pend discarded, bal unchanged, busy=1. Later `rst` low mid-BUSY → all outputs 0.

Source files
------------

// File: rtl/wallet_pkg.sv
// Shared types and constants for the coin wallet: FSM states, coin values, BCD ceiling.
package wallet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TOPUP  = 2'd1,
    ST_BUSY   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic [11:0] COIN_1  = 12'h001;
  localparam logic [11:0] COIN_5  = 12'h005;
  localparam logic [11:0] COIN_10 = 12'h010;
  localparam logic [11:0] COIN_50 = 12'h050;
  localparam logic [11:0] BCD_MAX = 12'h999;

  function automatic logic [11:0] coin_value(input logic [1:0] denom);
    case (denom)
      2'b00:   return COIN_1;
      2'b01:   return COIN_5;
      2'b10:   return COIN_10;
      default: return COIN_50;
    endcase
  endfunction

endpackage

// File: rtl/bcd3_addsub.sv
// Combinational 3-digit BCD add/subtract with ripple carry/borrow between digits.
module bcd3_addsub (
  input  logic [11:0] i_a,
  input  logic [11:0] i_b,
  input  logic        i_sub,
  output logic [11:0] o_res,
  output logic        o_cout,
  output logic        o_bout
);

  logic [4:0] w_d;
  logic       w_c;

  always_comb begin
    w_d   = '0;
    w_c   = 1'b0;
    o_res = '0;
    for (int i = 0; i < 3; i++) begin
      if (!i_sub) begin
        w_d = {1'b0, i_a[i*4 +: 4]} + {1'b0, i_b[i*4 +: 4]} + {4'b0, w_c};
        w_c = (w_d > 5'd9);
        if (w_c) w_d = w_d - 5'd10;
      end else begin
        // a negative 5-bit difference wraps; adding 10 back yields the digit
        w_d = {1'b0, i_a[i*4 +: 4]} - {1'b0, i_b[i*4 +: 4]} - {4'b0, w_c};
        w_c = w_d[4];
        if (w_c) w_d = w_d + 5'd10;
      end
      o_res[i*4 +: 4] = w_d[3:0];
    end
  end

  assign o_cout = w_c & ~i_sub;
  assign o_bout = w_c &  i_sub;

endmodule

// File: rtl/coin_wallet.sv
// Customer credit keeper: coin top-ups, balance lock during a wash, fee deduction on completion.
module coin_wallet
  import wallet_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned TIMEOUT_SEC   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        on,
  input  logic        add_pos,
  input  logic [1:0]  denom,
  input  logic        confirm_pos,
  input  logic        cancel_pos,
  input  logic [11:0] income,
  input  logic        next,
  output logic [11:0] bal,
  output logic [11:0] pend,
  output logic        busy,
  output logic        sat,
  output logic        short
);

  localparam logic [30:0] TIMEOUT_CYC = 31'(TIMEOUT_SEC * TICKS_PER_SEC);

  state_t      r_state, w_state_nxt;
  logic [11:0] r_bal, r_pend, r_hold;
  logic [11:0] w_bal_nxt, w_pend_nxt, w_hold_nxt;
  logic [30:0] r_cnt, w_cnt_nxt;
  logic        r_next_d, r_busy, r_sat, r_short;
  logic        w_sat_nxt, w_short_nxt, w_busy_nxt;

  logic [11:0] w_coin, w_pc, w_bp_in, w_bp, w_room, w_set, w_topup_pend;
  logic        w_pc_c, w_pc_b, w_bp_c, w_bp_b, w_room_c, w_room_b, w_set_c, w_set_b;
  logic        w_topup_clip;
  logic        w_unused_flags;

  assign w_coin  = coin_value(denom);
  // a commit adds the standing pend; a coin adds the grown pend
  assign w_bp_in = (r_state == ST_TOPUP && confirm_pos) ? r_pend : w_pc;

  bcd3_addsub u_pc   (.i_a(r_pend),  .i_b(w_coin),  .i_sub(1'b0), .o_res(w_pc),   .o_cout(w_pc_c),   .o_bout(w_pc_b));
  bcd3_addsub u_bp   (.i_a(r_bal),   .i_b(w_bp_in), .i_sub(1'b0), .o_res(w_bp),   .o_cout(w_bp_c),   .o_bout(w_bp_b));
  bcd3_addsub u_room (.i_a(BCD_MAX), .i_b(r_bal),   .i_sub(1'b1), .o_res(w_room), .o_cout(w_room_c), .o_bout(w_room_b));
  bcd3_addsub u_set  (.i_a(r_bal),   .i_b(r_hold),  .i_sub(1'b1), .o_res(w_set),  .o_cout(w_set_c),  .o_bout(w_set_b));

  assign w_unused_flags = w_pc_b ^ w_bp_b ^ w_room_c ^ w_room_b ^ w_set_c;

  // clipping leaves exactly the room up to 999 in pend
  assign w_topup_clip = w_pc_c | w_bp_c;
  assign w_topup_pend = w_topup_clip ? w_room : w_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_bal_nxt   = r_bal;
    w_pend_nxt  = r_pend;
    w_hold_nxt  = r_hold;
    w_cnt_nxt   = '0;
    w_sat_nxt   = 1'b0;
    w_short_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (on) begin
          w_state_nxt = ST_BUSY;
        end else if (add_pos) begin
          w_state_nxt = ST_TOPUP;
          w_pend_nxt  = w_topup_pend;
          w_sat_nxt   = w_topup_clip;
        end
      end
      ST_TOPUP: begin
        if (on) begin
          w_state_nxt = ST_BUSY;
          w_pend_nxt  = '0;
        end else if (confirm_pos) begin
          w_state_nxt = ST_IDLE;
          w_pend_nxt  = '0;
          w_bal_nxt   = w_bp_c ? BCD_MAX : w_bp;
          w_sat_nxt   = w_bp_c;
        end else if (cancel_pos) begin
          w_state_nxt = ST_IDLE;
          w_pend_nxt  = '0;
        end else if (add_pos) begin
          w_pend_nxt  = w_topup_pend;
          w_sat_nxt   = w_topup_clip;
        end else if (r_cnt == TIMEOUT_CYC - 31'd1) begin
          w_state_nxt = ST_IDLE;
          w_pend_nxt  = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 31'd1;
        end
      end
      ST_BUSY: begin
        if (income != '0) w_hold_nxt = income;
        if (next && !r_next_d) begin
          w_state_nxt = ST_SETTLE;
        end else if (!on) begin
          w_state_nxt = ST_IDLE;
          w_hold_nxt  = '0;
        end
      end
      ST_SETTLE: begin
        w_bal_nxt   = w_set_b ? '0 : w_set;
        w_short_nxt = w_set_b;
        w_hold_nxt  = '0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_busy_nxt = (w_state_nxt == ST_BUSY) || (w_state_nxt == ST_SETTLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_bal    <= '0;
      r_pend   <= '0;
      r_hold   <= '0;
      r_cnt    <= '0;
      r_next_d <= 1'b0;
      r_busy   <= 1'b0;
      r_sat    <= 1'b0;
      r_short  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bal    <= w_bal_nxt;
      r_pend   <= w_pend_nxt;
      r_hold   <= w_hold_nxt;
      r_cnt    <= w_cnt_nxt;
      r_next_d <= next;
      r_busy   <= w_busy_nxt;
      r_sat    <= w_sat_nxt;
      r_short  <= w_short_nxt;
    end
  end

  assign bal   = r_bal;
  assign pend  = r_pend;
  assign busy  = r_busy;
  assign sat   = r_sat;
  assign short = r_short;

endmodule

// File: tb/tb_coin_wallet.sv
// Self-checking bench for coin_wallet: vector table, directed corner sequences, random run vs. model.
module tb_coin_wallet;

  localparam int LIMIT = 20;  // TICKS_PER_SEC * TIMEOUT_SEC below

  logic        clk, rst;
  logic        t_on, t_add, t_cf, t_cn, t_next;
  logic [1:0]  t_dn;
  logic [11:0] t_inc;
  logic [11:0] bal, pend;
  logic        busy, sat, short;

  coin_wallet #(.TICKS_PER_SEC(10), .TIMEOUT_SEC(2)) dut (
    .clk(clk), .rst(rst), .on(t_on), .add_pos(t_add), .denom(t_dn),
    .confirm_pos(t_cf), .cancel_pos(t_cn), .income(t_inc), .next(t_next),
    .bal(bal), .pend(pend), .busy(busy), .sat(sat), .short(short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       on, add;
    logic [1:0] dn;
    logic       cf, cn;
    logic [11:0] inc;
    logic       nx;
  } in_t;

  typedef struct {
    in_t        i;
    logic [11:0] bal, pend;
    logic       busy, sat, short;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: decimal integers and plain mode flags
  int m_bal, m_pend, m_hold, m_cnt;
  bit m_topup, m_wash, m_settle, m_sat, m_short, m_nd;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic int from_bcd(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int coin(input logic [1:0] d);
    case (d)
      2'b00:   return 1;
      2'b01:   return 5;
      2'b10:   return 10;
      default: return 50;
    endcase
  endfunction

  function automatic in_t mk(input logic on, input logic add, input logic [1:0] dn,
                             input logic cf, input logic cn, input logic [11:0] inc, input logic nx);
    in_t x;
    x.on = on; x.add = add; x.dn = dn; x.cf = cf; x.cn = cn; x.inc = inc; x.nx = nx;
    return x;
  endfunction

  task automatic model_reset();
    m_bal = 0; m_pend = 0; m_hold = 0; m_cnt = 0;
    m_topup = 0; m_wash = 0; m_settle = 0; m_sat = 0; m_short = 0; m_nd = 0;
  endtask

  task automatic model_add_coin(input logic [1:0] d);
    int p;
    p = m_pend + coin(d);
    if (m_bal + p > 999) begin
      p = 999 - m_bal;
      m_sat = 1;
    end
    m_pend = p;
    m_cnt = 0;
  endtask

  task automatic model_step(input in_t x);
    bit edge_nx;
    int s;
    m_sat = 0;
    m_short = 0;
    edge_nx = x.nx && !m_nd;
    m_nd = x.nx;
    if (m_settle) begin
      if (m_hold <= m_bal) m_bal = m_bal - m_hold;
      else begin m_bal = 0; m_short = 1; end
      m_hold = 0;
      m_settle = 0;
    end else if (m_wash) begin
      if (x.inc != 12'h000) m_hold = from_bcd(x.inc);
      if (edge_nx) begin m_wash = 0; m_settle = 1; end
      else if (!x.on) begin m_wash = 0; m_hold = 0; end
    end else if (m_topup) begin
      if (x.on) begin m_pend = 0; m_topup = 0; m_wash = 1; end
      else if (x.cf) begin
        s = m_bal + m_pend;
        if (s > 999) begin s = 999; m_sat = 1; end
        m_bal = s; m_pend = 0; m_topup = 0;
      end
      else if (x.cn) begin m_pend = 0; m_topup = 0; end
      else if (x.add) model_add_coin(x.dn);
      else if (m_cnt == LIMIT - 1) begin m_pend = 0; m_topup = 0; end
      else m_cnt++;
    end else begin
      if (x.on) m_wash = 1;
      else if (x.add) begin m_topup = 1; m_pend = 0; model_add_coin(x.dn); end
    end
  endtask

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".bal"},   bal,          to_bcd(m_bal));
    chk({tag, ".pend"},  pend,         to_bcd(m_pend));
    chk({tag, ".busy"},  {11'b0, busy},  {11'b0, (m_wash | m_settle)});
    chk({tag, ".sat"},   {11'b0, sat},   {11'b0, m_sat});
    chk({tag, ".short"}, {11'b0, short}, {11'b0, m_short});
  endtask

  // drive one cycle of inputs; outputs are read 1 ns after the edge
  task automatic cycle(input in_t x);
    t_on = x.on; t_add = x.add; t_dn = x.dn; t_cf = x.cf; t_cn = x.cn; t_inc = x.inc; t_next = x.nx;
    model_step(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    t_on = 0; t_add = 0; t_dn = 0; t_cf = 0; t_cn = 0; t_inc = 0; t_next = 0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) cycle(mk(0, 0, 2'b00, 0, 0, 12'h000, 0));
  endtask

  task automatic add_n(input logic [1:0] d, input int n);
    for (int k = 0; k < n; k++) cycle(mk(0, 1, d, 0, 0, 12'h000, 0));
  endtask

  vec_t tbl[$];

  task automatic push(input in_t x, input logic [11:0] b, input logic [11:0] p,
                      input logic bz, input logic st, input logic sh);
    vec_t v;
    v.i = x; v.bal = b; v.pend = p; v.busy = bz; v.sat = st; v.short = sh;
    tbl.push_back(v);
  endtask

  initial begin
    in_t x;
    do_reset();

    chk("reset.bal", bal, 12'h000);
    chk("reset.pend", pend, 12'h000);
    chk("reset.busy", {11'b0, busy}, 12'h000);
    chk("reset.sat", {11'b0, sat}, 12'h000);
    chk("reset.short", {11'b0, short}, 12'h000);

    // coin sum 066, then raise to 120 and run a wash billed 045 with next held 5 cycles
    push(mk(0, 1, 2'b11, 0, 0, 12'h000, 0), 12'h000, 12'h050, 0, 0, 0);
    push(mk(0, 1, 2'b10, 0, 0, 12'h000, 0), 12'h000, 12'h060, 0, 0, 0);
    push(mk(0, 1, 2'b01, 0, 0, 12'h000, 0), 12'h000, 12'h065, 0, 0, 0);
    push(mk(0, 1, 2'b00, 0, 0, 12'h000, 0), 12'h000, 12'h066, 0, 0, 0);
    push(mk(0, 0, 2'b00, 1, 0, 12'h000, 0), 12'h066, 12'h000, 0, 0, 0);
    push(mk(0, 1, 2'b11, 0, 0, 12'h000, 0), 12'h066, 12'h050, 0, 0, 0);
    push(mk(0, 1, 2'b00, 0, 0, 12'h000, 0), 12'h066, 12'h051, 0, 0, 0);
    push(mk(0, 1, 2'b00, 0, 0, 12'h000, 0), 12'h066, 12'h052, 0, 0, 0);
    push(mk(0, 1, 2'b00, 1, 1, 12'h000, 0), 12'h118, 12'h000, 0, 0, 0);
    push(mk(0, 1, 2'b00, 0, 0, 12'h000, 0), 12'h118, 12'h001, 0, 0, 0);
    push(mk(0, 1, 2'b00, 0, 1, 12'h000, 0), 12'h118, 12'h000, 0, 0, 0);
    push(mk(0, 1, 2'b00, 0, 0, 12'h000, 0), 12'h118, 12'h001, 0, 0, 0);
    push(mk(0, 1, 2'b00, 0, 0, 12'h000, 0), 12'h118, 12'h002, 0, 0, 0);
    push(mk(0, 0, 2'b00, 1, 0, 12'h000, 0), 12'h120, 12'h000, 0, 0, 0);
    push(mk(1, 0, 2'b00, 0, 0, 12'h000, 0), 12'h120, 12'h000, 1, 0, 0);
    push(mk(1, 1, 2'b11, 1, 0, 12'h045, 0), 12'h120, 12'h000, 1, 0, 0);
    push(mk(1, 0, 2'b00, 0, 0, 12'h000, 0), 12'h120, 12'h000, 1, 0, 0);
    push(mk(1, 0, 2'b00, 0, 0, 12'h000, 1), 12'h120, 12'h000, 1, 0, 0);
    push(mk(1, 0, 2'b00, 0, 0, 12'h000, 1), 12'h075, 12'h000, 0, 0, 0);
    push(mk(1, 0, 2'b00, 0, 0, 12'h000, 1), 12'h075, 12'h000, 1, 0, 0);
    push(mk(1, 0, 2'b00, 0, 0, 12'h000, 1), 12'h075, 12'h000, 1, 0, 0);
    push(mk(1, 0, 2'b00, 0, 0, 12'h000, 1), 12'h075, 12'h000, 1, 0, 0);
    push(mk(0, 0, 2'b00, 0, 0, 12'h000, 0), 12'h075, 12'h000, 0, 0, 0);
    push(mk(0, 0, 2'b00, 0, 0, 12'h000, 0), 12'h075, 12'h000, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].i);
      chk($sformatf("vec%0d.bal", i), bal, tbl[i].bal);
      chk($sformatf("vec%0d.pend", i), pend, tbl[i].pend);
      chk($sformatf("vec%0d.busy", i), {11'b0, busy}, {11'b0, tbl[i].busy});
      chk($sformatf("vec%0d.sat", i), {11'b0, sat}, {11'b0, tbl[i].sat});
      chk($sformatf("vec%0d.short", i), {11'b0, short}, {11'b0, tbl[i].short});
    end

    // clip at 999: bal 990, coin 50 leaves pend 009
    do_reset();
    add_n(2'b11, 19);
    add_n(2'b10, 4);
    chk("sat.pend990", pend, 12'h990);
    cycle(mk(0, 0, 2'b00, 1, 0, 12'h000, 0));
    chk("sat.bal990", bal, 12'h990);
    cycle(mk(0, 1, 2'b11, 0, 0, 12'h000, 0));
    chk("sat.pend009", pend, 12'h009);
    chk("sat.pulse", {11'b0, sat}, 12'h001);
    idle_n(1);
    chk("sat.pulse_end", {11'b0, sat}, 12'h000);
    cycle(mk(0, 0, 2'b00, 1, 0, 12'h000, 0));
    chk("sat.bal999", bal, 12'h999);
    chk("sat.pend0", pend, 12'h000);

    // fee larger than balance
    do_reset();
    add_n(2'b10, 3);
    cycle(mk(0, 0, 2'b00, 1, 0, 12'h000, 0));
    chk("short.bal030", bal, 12'h030);
    cycle(mk(1, 0, 2'b00, 0, 0, 12'h000, 0));
    cycle(mk(1, 0, 2'b00, 0, 0, 12'h045, 0));
    cycle(mk(1, 0, 2'b00, 0, 0, 12'h045, 1));
    chk("short.settle_busy", {11'b0, busy}, 12'h001);
    cycle(mk(1, 0, 2'b00, 0, 0, 12'h045, 1));
    chk("short.bal0", bal, 12'h000);
    chk("short.pulse", {11'b0, short}, 12'h001);
    cycle(mk(0, 0, 2'b00, 0, 0, 12'h000, 0));
    chk("short.pulse_end", {11'b0, short}, 12'h000);

    // abandoned top-up expires 20 cycles after the last coin
    do_reset();
    add_n(2'b01, 1);
    idle_n(LIMIT - 1);
    chk("tmo.pend_before", pend, 12'h005);
    idle_n(1);
    chk("tmo.pend_after", pend, 12'h000);
    chk("tmo.bal", bal, 12'h000);

    // wash start outranks confirm; then reset mid-wash
    do_reset();
    add_n(2'b10, 1);
    cycle(mk(0, 0, 2'b00, 1, 0, 12'h000, 0));
    add_n(2'b01, 1);
    cycle(mk(1, 0, 2'b00, 1, 0, 12'h000, 0));
    chk("onconf.pend", pend, 12'h000);
    chk("onconf.bal", bal, 12'h010);
    chk("onconf.busy", {11'b0, busy}, 12'h001);
    cycle(mk(1, 0, 2'b00, 0, 0, 12'h030, 0));
    #2 rst = 1'b0;
    #1;
    chk("rst.bal", bal, 12'h000);
    chk("rst.pend", pend, 12'h000);
    chk("rst.busy", {11'b0, busy}, 12'h000);
    chk("rst.sat", {11'b0, sat}, 12'h000);
    chk("rst.short", {11'b0, short}, 12'h000);

    // random traffic against the model
    do_reset();
    x = mk(0, 0, 2'b00, 0, 0, 12'h000, 0);
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 24) == 0) x.on = ~x.on;
      if ($urandom_range(0, 5) == 0) x.nx = ~x.nx;
      x.add = ($urandom_range(0, 3) == 0);
      x.dn  = 2'($urandom_range(0, 3));
      x.cf  = ($urandom_range(0, 11) == 0);
      x.cn  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 2) == 0)
        x.inc = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else
        x.inc = 12'h000;
      cycle(x);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
